// File: rtl/am_init_if.sv
// AM init line bundle: request in, AM chip / FIFO reset controls and status out.
interface am_init_if;
    logic       am_init;
    logic       am_rst;
    logic       resfifon;
    logic       busy;
    logic       init_done;
    logic [7:0] init_cnt;

    modport master (output am_init, input am_rst, resfifon, busy, init_done, init_cnt);
    modport slave  (input am_init, output am_rst, resfifon, busy, init_done, init_cnt);
endinterface

// File: rtl/am_init_seq.sv
// Receive end of the AM init line: qualifies the stretched request and runs
// chip reset -> FIFO reset -> settle, closing with init_done and a count.
module am_init_seq #(
    parameter int MIN_W      = 2,
    parameter int RST_LEN    = 8,
    parameter int FIFO_LEN   = 2,
    parameter int SETTLE_LEN = 16,
    parameter int CNT_W      = 5
) (
    input  logic      clk,
    input  logic      rst,
    am_init_if.slave  bus
);
    localparam int HW = $clog2(MIN_W + 1);
    localparam logic [CNT_W-1:0] L_RST = CNT_W'(RST_LEN - 1);
    localparam logic [CNT_W-1:0] L_FIF = CNT_W'(FIFO_LEN - 1);
    localparam logic [CNT_W-1:0] L_SET = CNT_W'(SETTLE_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_FIFO, S_SETTLE, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_ph;
    logic [HW-1:0]    r_hi_cnt;
    logic             r_armed;
    logic             r_am_rst;
    logic             r_resfifon;
    logic             r_busy;
    logic             r_init_done;
    logic [7:0]       r_init_cnt;

    logic w_reach;
    logic w_accept;

    // This high sample brings hi_cnt up to MIN_W.
    assign w_reach  = (32'(r_hi_cnt) + 32'd1) >= 32'(MIN_W);
    assign w_accept = bus.am_init && r_armed && w_reach;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ph        <= '0;
            r_hi_cnt    <= '0;
            r_armed     <= 1'b1;
            r_am_rst    <= 1'b0;
            r_resfifon  <= 1'b1;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_init_cnt  <= '0;
        end else begin
            r_hi_cnt    <= !bus.am_init ? '0 : (w_reach ? HW'(MIN_W) : r_hi_cnt + HW'(1));
            r_armed     <= !bus.am_init || (r_armed && !w_accept);
            r_init_done <= 1'b0;
            // An accepted request restarts from RESET in any state, aborting a running sequence.
            if (w_accept) begin
                r_state    <= S_RESET;
                r_ph       <= '0;
                r_am_rst   <= 1'b1;
                r_resfifon <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_RESET:
                        if (r_ph == L_RST) begin
                            r_state    <= S_FIFO;
                            r_ph       <= '0;
                            r_resfifon <= 1'b0;
                        end else r_ph <= r_ph + CNT_W'(1);
                    S_FIFO:
                        if (r_ph == L_FIF) begin
                            r_state    <= S_SETTLE;
                            r_ph       <= '0;
                            r_am_rst   <= 1'b0;
                            r_resfifon <= 1'b1;
                        end else r_ph <= r_ph + CNT_W'(1);
                    S_SETTLE:
                        if (r_ph == L_SET) begin
                            r_state     <= S_DONE;
                            r_ph        <= '0;
                            r_busy      <= 1'b0;
                            r_init_done <= 1'b1;
                            r_init_cnt  <= r_init_cnt + 8'd1;
                        end else r_ph <= r_ph + CNT_W'(1);
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.am_rst    = r_am_rst;
    assign bus.resfifon  = r_resfifon;
    assign bus.busy      = r_busy;
    assign bus.init_done = r_init_done;
    assign bus.init_cnt  = r_init_cnt;
endmodule

// File: tb/tb_am_init_seq.sv
// Bench for am_init_seq: a default-parameter instance and a minimum-length
// instance, each checked every cycle against a time-since-accept model.
module tb_am_init_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    am_init_if if_a ();
    am_init_if if_b ();

    am_init_seq dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    am_init_seq #(.MIN_W(1), .RST_LEN(1), .FIFO_LEN(1), .SETTLE_LEN(1), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: per instance, qualifier state plus cycles elapsed since the
    // accepting edge (-1 when idle). Outputs follow from that elapsed time.
    int  pmin[2] = '{2, 1};
    int  plr[2]  = '{8, 1};
    int  plf[2]  = '{2, 1};
    int  pls[2]  = '{16, 1};
    int  m_hi[2], m_t[2], m_cnt[2];
    bit  m_armed[2];

    always @(posedge clk) begin
        logic ain, rr;
        bit   acc;
        int   tot;
        for (int k = 0; k < 2; k++) begin
            ain = (k == 0) ? if_a.am_init : if_b.am_init;
            rr  = (k == 0) ? rst_a : rst_b;
            tot = plr[k] + plf[k] + pls[k];
            if (rr) begin
                m_hi[k] = 0; m_armed[k] = 1; m_t[k] = -1; m_cnt[k] = 0;
            end else begin
                acc = ain && m_armed[k] && (m_hi[k] + 1 >= pmin[k]);
                m_hi[k] = ain ? ((m_hi[k] + 1 > pmin[k]) ? pmin[k] : m_hi[k] + 1) : 0;
                if (!ain) m_armed[k] = 1;
                else if (acc) m_armed[k] = 0;
                if (acc) m_t[k] = 0;
                else if (m_t[k] == tot) m_t[k] = -1;
                else if (m_t[k] >= 0) begin
                    m_t[k]++;
                    if (m_t[k] == tot) m_cnt[k] = (m_cnt[k] + 1) % 256;
                end
            end
        end
    end

    always @(negedge clk) begin
        int t, r, f, tot;
        string p;
        for (int k = 0; k < 2; k++) begin
            t = m_t[k]; r = plr[k]; f = plf[k]; tot = r + f + pls[k];
            p = (k == 0) ? "A" : "B";
            check({p, "_am_rst"},    int'(k == 0 ? if_a.am_rst    : if_b.am_rst),    int'(t >= 0 && t < r + f));
            check({p, "_resfifon"},  int'(k == 0 ? if_a.resfifon  : if_b.resfifon),  int'(!(t >= r && t < r + f)));
            check({p, "_busy"},      int'(k == 0 ? if_a.busy      : if_b.busy),      int'(t >= 0 && t < tot));
            check({p, "_init_done"}, int'(k == 0 ? if_a.init_done : if_b.init_done), int'(t == tot));
            check({p, "_init_cnt"},  int'(k == 0 ? if_a.init_cnt  : if_b.init_cnt),  m_cnt[k]);
        end
    end

    // Directed window on instance A: two high intervals, optional rst cycle,
    // and one snapshot; accumulates what the outputs did.
    int w_rst_hi, w_fifo_lo, w_busy_hi, w_done, w_done_i, w_rise_i;
    int s_am_rst, s_resf, s_busy, s_cnt;

    task automatic a_run(input int n, input int s1, input int e1, input int s2, input int e2,
                         input int rst_at);
        logic pv;
        w_rst_hi = 0; w_fifo_lo = 0; w_busy_hi = 0; w_done = 0; w_done_i = -1; w_rise_i = -1;
        pv = if_a.am_rst;
        for (int i = 0; i < n; i++) begin
            if_a.am_init = ((i >= s1 && i < e1) || (i >= s2 && i < e2));
            rst_a = (i == rst_at);
            @(negedge clk);
            if (if_a.am_rst)    w_rst_hi++;
            if (!if_a.resfifon) w_fifo_lo++;
            if (if_a.busy)      w_busy_hi++;
            if (if_a.init_done) begin w_done++; w_done_i = i; end
            if (if_a.am_rst && !pv) w_rise_i = i;
            pv = if_a.am_rst;
            if (i == rst_at) begin
                s_am_rst = int'(if_a.am_rst); s_resf = int'(if_a.resfifon);
                s_busy = int'(if_a.busy); s_cnt = int'(if_a.init_cnt);
            end
        end
        if_a.am_init = 1'b0;
        rst_a = 1'b0;
    endtask

    initial begin
        int b_done, b_rise, b_bad, b_wrap, prev_cnt, run;
        logic lvl;
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.am_init = 1'b0; if_b.am_init = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("reset_am_rst", int'(if_a.am_rst), 0);
        check("reset_resfifon", int'(if_a.resfifon), 1);
        check("reset_busy", int'(if_a.busy), 0);
        check("reset_done", int'(if_a.init_done), 0);
        check("reset_cnt", int'(if_a.init_cnt), 0);

        a_run(10, 0, 1, 0, 0, -1);
        check("glitch_done", w_done, 0);
        check("glitch_am_rst", w_rst_hi, 0);
        check("glitch_cnt", int'(if_a.init_cnt), 0);

        a_run(40, 0, 4, 0, 0, -1);
        check("seq_rise_at", w_rise_i, 1);
        check("seq_am_rst_len", w_rst_hi, 10);
        check("seq_fifo_len", w_fifo_lo, 2);
        check("seq_busy_len", w_busy_hi, 26);
        check("seq_done_n", w_done, 1);
        check("seq_done_lat", w_done_i - w_rise_i, 26);
        check("seq_cnt", int'(if_a.init_cnt), 1);

        a_run(60, 0, 40, 0, 0, -1);
        check("level_done_n", w_done, 1);
        check("level_cnt", int'(if_a.init_cnt), 2);
        a_run(40, 2, 6, 0, 0, -1);
        check("relevel_done_n", w_done, 1);
        check("relevel_cnt", int'(if_a.init_cnt), 3);

        a_run(60, 0, 4, 14, 18, -1);
        check("restart_rise_at", w_rise_i, 15);
        check("restart_am_rst", w_rst_hi, 20);
        check("restart_done_n", w_done, 1);
        check("restart_done_at", w_done_i, 41);
        check("restart_cnt", int'(if_a.init_cnt), 4);

        a_run(20, 0, 4, 0, 0, 10);
        check("abort_am_rst", s_am_rst, 0);
        check("abort_resfifon", s_resf, 1);
        check("abort_busy", s_busy, 0);
        check("abort_cnt", s_cnt, 0);
        check("abort_done_n", w_done, 0);

        // Back-to-back minimum-length sequences on B, each restarted from DONE.
        b_done = 0; b_rise = -1; b_bad = 0; b_wrap = 0; prev_cnt = int'(if_b.init_cnt);
        for (int i = 0; i < 1024; i++) begin
            if_b.am_init = (i % 4 == 0);
            @(negedge clk);
            if (if_b.am_rst && (b_rise < 0 || i - b_rise > 1)) b_rise = i;
            if (if_b.init_done) begin
                b_done++;
                if (i - b_rise != 3) b_bad++;
            end
            if (prev_cnt == 255 && int'(if_b.init_cnt) == 0) b_wrap++;
            prev_cnt = int'(if_b.init_cnt);
        end
        if_b.am_init = 1'b0;
        @(negedge clk);
        check("wrap_done_n", b_done, 256);
        check("wrap_lat_bad", b_bad, 0);
        check("wrap_seen", b_wrap, 1);
        check("wrap_cnt", int'(if_b.init_cnt), 0);

        // Random levels with occasional reset on both instances.
        run = 0; lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                lvl = $urandom_range(0, 1);
                run = $urandom_range(1, 6);
            end
            run--;
            if_a.am_init = lvl;
            if_b.am_init = $urandom_range(0, 1);
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        if_a.am_init = 1'b0; if_b.am_init = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
